// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the hazard scoreboard slice: default parameter
// values and the stall reason encoding driven on stallReason.
// No ports (package).
package hazard_pkg;

  localparam int DEFAULT_REGISTER_COUNT = 32;
  localparam int DEFAULT_INDEX_WIDTH    = 5;
  localparam int DEFAULT_MAX_LATENCY    = 7;
  localparam int DEFAULT_LATENCY_WIDTH  = 3;

  // Reason codes, listed from lowest to highest priority
  typedef enum logic [1:0] {
    STALL_NONE        = 2'd0,
    STALL_DATA_HAZARD = 2'd1,
    STALL_INSTR_MEM   = 2'd2,
    STALL_DATA_MEM    = 2'd3
  } stall_reason_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if
// Groups the decode-stage request signals and the scoreboard status outputs.
// master: pipeline side (drives decode info and memory-blocked flags,
//         observes stall, reason, busy mask and stall count)
// slave : scoreboard side (the opposite directions)
interface hazard_scoreboard_if
  import hazard_pkg::*;
#(
  parameter int REGISTER_COUNT = DEFAULT_REGISTER_COUNT,
  parameter int INDEX_WIDTH    = DEFAULT_INDEX_WIDTH,
  parameter int MAX_LATENCY    = DEFAULT_MAX_LATENCY,
  parameter int LATENCY_WIDTH  = DEFAULT_LATENCY_WIDTH
) ();

  logic [INDEX_WIDTH-1:0]    decodeStageLHSReadRegisterIndex;
  logic [INDEX_WIDTH-1:0]    decodeStageRHSReadRegisterIndex;
  logic [INDEX_WIDTH-1:0]    decodeStageWriteRegisterIndex;
  logic [LATENCY_WIDTH-1:0]  decodeStageWriteLatency;
  logic                      isDecodeStageValid;
  logic                      isInstructionMemoryBlocked;
  logic                      isDataMemoryBlocked;
  logic                      isPipelineFlushed;
  logic                      isPipelineStalled;
  logic [1:0]                stallReason;
  logic [REGISTER_COUNT-1:0] busyRegisterMask;
  logic [31:0]               stallCycleCount;

  modport master (
    output decodeStageLHSReadRegisterIndex, decodeStageRHSReadRegisterIndex,
           decodeStageWriteRegisterIndex, decodeStageWriteLatency,
           isDecodeStageValid, isInstructionMemoryBlocked,
           isDataMemoryBlocked, isPipelineFlushed,
    input  isPipelineStalled, stallReason, busyRegisterMask, stallCycleCount
  );

  modport slave (
    input  decodeStageLHSReadRegisterIndex, decodeStageRHSReadRegisterIndex,
           decodeStageWriteRegisterIndex, decodeStageWriteLatency,
           isDecodeStageValid, isInstructionMemoryBlocked,
           isDataMemoryBlocked, isPipelineFlushed,
    output isPipelineStalled, stallReason, busyRegisterMask, stallCycleCount
  );

endinterface

// File: rtl/hazard_scoreboard_entry.sv
// scoreboard_entry
// One register's pending-result down-counter.
// Ports:
//   clk, reset  - clock and asynchronous active-high reset
//   load        - an issuing instruction targets this register
//   load_value  - latency to load (already clamped, nonzero)
//   count       - cycles left until the result is forwardable
//   busy        - count is nonzero
module scoreboard_entry
  import hazard_pkg::*;
#(
  parameter int LATENCY_WIDTH = DEFAULT_LATENCY_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [LATENCY_WIDTH-1:0] load_value,
  output logic [LATENCY_WIDTH-1:0] count,
  output logic                     busy
);

  // A new issue replaces whatever was pending; otherwise count down to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Decode-stage hazard detection: tracks pending register writes, stalls
// fetch/decode on data hazards or blocked memories, reports the stall reason
// and keeps a saturating count of stalled cycles.
// Ports:
//   clk, reset - clock and asynchronous active-high reset
//   bus        - hazard_scoreboard_if.slave (decode request, memory-blocked
//                flags, flush; stall, stallReason, busyRegisterMask,
//                stallCycleCount)
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REGISTER_COUNT = DEFAULT_REGISTER_COUNT,
  parameter int INDEX_WIDTH    = DEFAULT_INDEX_WIDTH,
  parameter int MAX_LATENCY    = DEFAULT_MAX_LATENCY,
  parameter int LATENCY_WIDTH  = DEFAULT_LATENCY_WIDTH
) (
  input logic             clk,
  input logic             reset,
  hazard_scoreboard_if.slave bus
);

  logic [LATENCY_WIDTH-1:0]  counts [REGISTER_COUNT];
  logic [REGISTER_COUNT-1:0] busy;
  logic [LATENCY_WIDTH-1:0]  clamped_latency;
  logic                      lhs_pending;
  logic                      rhs_pending;
  logic                      waw_pending;
  logic                      data_hazard;
  logic                      stalled;
  logic                      issue;
  logic [31:0]               stall_count_q;
  stall_reason_t             reason;

  // Clamp only when the counter can represent values above MAX_LATENCY
  if (MAX_LATENCY < (1 << LATENCY_WIDTH) - 1) begin : g_clamp
    assign clamped_latency =
      (bus.decodeStageWriteLatency > LATENCY_WIDTH'(MAX_LATENCY))
        ? LATENCY_WIDTH'(MAX_LATENCY) : bus.decodeStageWriteLatency;
  end else begin : g_no_clamp
    assign clamped_latency = bus.decodeStageWriteLatency;
  end

  // Register 0 is hardwired zero and never tracked
  assign counts[0] = '0;
  assign busy[0]   = 1'b0;

  for (genvar i = 1; i < REGISTER_COUNT; i++) begin : g_entry
    scoreboard_entry #(
      .LATENCY_WIDTH(LATENCY_WIDTH)
    ) u_entry (
      .clk       (clk),
      .reset     (reset),
      .load      (issue && (bus.decodeStageWriteRegisterIndex == INDEX_WIDTH'(i))),
      .load_value(clamped_latency),
      .count     (counts[i]),
      .busy      (busy[i])
    );
  end

  // A result is forwardable in the cycle its counter reads 1, so a reader only
  // waits while the counter is above 1 (latency N costs N-1 stall cycles).
  // A writer waits until the older write would complete no later than its own.
  always_comb begin
    lhs_pending = (bus.decodeStageLHSReadRegisterIndex != '0) &&
                  (counts[bus.decodeStageLHSReadRegisterIndex] > LATENCY_WIDTH'(1));
    rhs_pending = (bus.decodeStageRHSReadRegisterIndex != '0) &&
                  (counts[bus.decodeStageRHSReadRegisterIndex] > LATENCY_WIDTH'(1));
    waw_pending = (bus.decodeStageWriteRegisterIndex != '0) &&
                  (counts[bus.decodeStageWriteRegisterIndex] > clamped_latency);
    data_hazard = !reset && bus.isDecodeStageValid &&
                  (lhs_pending || rhs_pending || waw_pending);
    stalled     = data_hazard || bus.isInstructionMemoryBlocked ||
                  bus.isDataMemoryBlocked;
    issue       = !reset && bus.isDecodeStageValid && !stalled &&
                  !bus.isPipelineFlushed &&
                  (bus.decodeStageWriteRegisterIndex != '0) &&
                  (clamped_latency != '0);
  end

  // Data memory outranks instruction memory, which outranks data hazards
  always_comb begin
    reason = STALL_NONE;
    if (bus.isDataMemoryBlocked) begin
      reason = STALL_DATA_MEM;
    end else if (bus.isInstructionMemoryBlocked) begin
      reason = STALL_INSTR_MEM;
    end else if (data_hazard) begin
      reason = STALL_DATA_HAZARD;
    end
  end

  // Saturating stalled-cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
    end else if (stalled && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign bus.isPipelineStalled = stalled;
  assign bus.stallReason       = reason;
  assign bus.busyRegisterMask  = busy;
  assign bus.stallCycleCount   = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
// Directed self-checking bench for hazard_scoreboard. Uses MAX_LATENCY=5 with
// a 3-bit latency field so that latency clamping is exercised.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int RC = 32;
  localparam int IW = 5;
  localparam int ML = 5;
  localparam int LW = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_stalls;

  hazard_scoreboard_if #(
    .REGISTER_COUNT(RC), .INDEX_WIDTH(IW), .MAX_LATENCY(ML), .LATENCY_WIDTH(LW)
  ) bus ();

  hazard_scoreboard #(
    .REGISTER_COUNT(RC), .INDEX_WIDTH(IW), .MAX_LATENCY(ML), .LATENCY_WIDTH(LW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic drive(input logic valid, input logic [IW-1:0] lhs,
                       input logic [IW-1:0] rhs, input logic [IW-1:0] wr,
                       input logic [LW-1:0] lat, input logic flush);
    bus.isDecodeStageValid              = valid;
    bus.decodeStageLHSReadRegisterIndex = lhs;
    bus.decodeStageRHSReadRegisterIndex = rhs;
    bus.decodeStageWriteRegisterIndex   = wr;
    bus.decodeStageWriteLatency         = lat;
    bus.isPipelineFlushed               = flush;
  endtask

  task automatic go_idle();
    drive(1'b0, '0, '0, '0, '0, 1'b0);
    bus.isInstructionMemoryBlocked = 1'b0;
    bus.isDataMemoryBlocked        = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go_idle();
    #2;
    checks += 3;
    if (bus.busyRegisterMask !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_mask: got %h expected 0", bus.busyRegisterMask);
    end
    if (bus.stallCycleCount !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_count: got %h expected 0", bus.stallCycleCount);
    end
    if (bus.isPipelineStalled !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.isPipelineStalled);
    end
    bus.isInstructionMemoryBlocked = 1'b1;
    #1;
    checks += 2;
    if (bus.isPipelineStalled !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_imem_stall: got %b expected 1", bus.isPipelineStalled);
    end
    if (bus.stallReason !== 2'd2) begin
      errors++; $display("[TB] FAIL reset_imem_reason: got %0d expected 2", bus.stallReason);
    end
    bus.isDataMemoryBlocked = 1'b1;
    #1;
    checks++;
    if (bus.stallReason !== 2'd3) begin
      errors++; $display("[TB] FAIL reset_dmem_reason: got %0d expected 3", bus.stallReason);
    end
    @(negedge clk);
    reset = 1'b0;
    go_idle();
    #1;
    checks++;
    if (bus.stallCycleCount !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_held_count: got %h expected 0", bus.stallCycleCount);
    end
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd0, 5'd0, 5'd5, 3'd2, 1'b0);
    #1;
    checks++;
    if (bus.isPipelineStalled !== 1'b0) begin
      errors++; $display("[TB] FAIL lu_issue_stall: got %b expected 0", bus.isPipelineStalled);
    end
    step();
    drive(1'b1, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0);
    #1;
    checks += 3;
    if (bus.busyRegisterMask !== 32'h0000_0020) begin
      errors++; $display("[TB] FAIL lu_mask: got %h expected 00000020", bus.busyRegisterMask);
    end
    if (bus.isPipelineStalled !== 1'b1) begin
      errors++; $display("[TB] FAIL lu_stall: got %b expected 1", bus.isPipelineStalled);
    end
    if (bus.stallReason !== 2'd1) begin
      errors++; $display("[TB] FAIL lu_reason: got %0d expected 1", bus.stallReason);
    end
    step();
    #1;
    exp_stalls += 1;
    checks += 2;
    if (bus.isPipelineStalled !== 1'b0) begin
      errors++; $display("[TB] FAIL lu_release: got %b expected 0", bus.isPipelineStalled);
    end
    if (bus.stallCycleCount !== 32'(exp_stalls)) begin
      errors++; $display("[TB] FAIL lu_count: got %0d expected %0d", bus.stallCycleCount, exp_stalls);
    end
    step();
    go_idle();
    #1;
    checks++;
    if (bus.busyRegisterMask !== 32'h0) begin
      errors++; $display("[TB] FAIL lu_drain: got %h expected 0", bus.busyRegisterMask);
    end
  endtask

  task automatic test_reg0();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 3'd3, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0);
    #1;
    checks += 2;
    if (bus.isPipelineStalled !== 1'b0) begin
      errors++; $display("[TB] FAIL r0_stall: got %b expected 0", bus.isPipelineStalled);
    end
    if (bus.busyRegisterMask !== 32'h0) begin
      errors++; $display("[TB] FAIL r0_mask: got %h expected 0", bus.busyRegisterMask);
    end
    go_idle();
    step();
  endtask

  task automatic test_waw();
    int stalls;
    drive(1'b1, 5'd0, 5'd0, 5'd7, 3'd5, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd7, 3'd1, 1'b0);
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (!bus.isPipelineStalled) break;
      stalls++;
      step();
    end
    checks += 2;
    if (stalls != 4) begin
      errors++; $display("[TB] FAIL waw_stalls: got %0d expected 4", stalls);
    end
    if (bus.busyRegisterMask !== 32'h0000_0080) begin
      errors++; $display("[TB] FAIL waw_pre_issue_mask: got %h expected 00000080", bus.busyRegisterMask);
    end
    step();
    go_idle();
    #1;
    checks++;
    if (bus.busyRegisterMask !== 32'h0000_0080) begin
      errors++; $display("[TB] FAIL waw_reload_mask: got %h expected 00000080", bus.busyRegisterMask);
    end
    step();
    #1;
    exp_stalls += 4;
    checks += 2;
    if (bus.busyRegisterMask !== 32'h0) begin
      errors++; $display("[TB] FAIL waw_drain: got %h expected 0", bus.busyRegisterMask);
    end
    if (bus.stallCycleCount !== 32'(exp_stalls)) begin
      errors++; $display("[TB] FAIL waw_count: got %0d expected %0d", bus.stallCycleCount, exp_stalls);
    end
  endtask

  task automatic test_latency_sweep();
    logic [LW-1:0] lats [3] = '{3'd1, 3'd3, 3'd7};
    int            want [3] = '{0, 2, 4};
    int            stalls;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd12, lats[k], 1'b0);
      step();
      drive(1'b1, 5'd12, 5'd0, 5'd0, 3'd0, 1'b0);
      stalls = 0;
      for (int i = 0; i < 12; i++) begin
        #1;
        if (!bus.isPipelineStalled) break;
        stalls++;
        step();
      end
      checks++;
      if (stalls != want[k]) begin
        errors++; $display("[TB] FAIL sweep_lat%0d: got %0d stalls expected %0d", lats[k], stalls, want[k]);
      end
      exp_stalls += want[k];
      go_idle();
      repeat (6) step();
    end
    checks++;
    if (bus.stallCycleCount !== 32'(exp_stalls)) begin
      errors++; $display("[TB] FAIL sweep_count: got %0d expected %0d", bus.stallCycleCount, exp_stalls);
    end
  endtask

  task automatic test_priority();
    drive(1'b1, 5'd0, 5'd0, 5'd3, 3'd5, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd0, 5'd0, 3'd0, 1'b0);
    bus.isDataMemoryBlocked        = 1'b1;
    bus.isInstructionMemoryBlocked = 1'b1;
    #1;
    checks += 2;
    if (bus.stallReason !== 2'd3) begin
      errors++; $display("[TB] FAIL prio_dmem: got %0d expected 3", bus.stallReason);
    end
    if (bus.isPipelineStalled !== 1'b1) begin
      errors++; $display("[TB] FAIL prio_stall: got %b expected 1", bus.isPipelineStalled);
    end
    step();
    bus.isDataMemoryBlocked = 1'b0;
    #1;
    checks++;
    if (bus.stallReason !== 2'd2) begin
      errors++; $display("[TB] FAIL prio_imem: got %0d expected 2", bus.stallReason);
    end
    step();
    bus.isInstructionMemoryBlocked = 1'b0;
    #1;
    checks++;
    if (bus.stallReason !== 2'd1) begin
      errors++; $display("[TB] FAIL prio_hazard: got %0d expected 1", bus.stallReason);
    end
    step();
    step();
    #1;
    exp_stalls += 4;
    checks += 3;
    if (bus.isPipelineStalled !== 1'b0) begin
      errors++; $display("[TB] FAIL prio_release: got %b expected 0", bus.isPipelineStalled);
    end
    if (bus.stallReason !== 2'd0) begin
      errors++; $display("[TB] FAIL prio_none: got %0d expected 0", bus.stallReason);
    end
    if (bus.stallCycleCount !== 32'(exp_stalls)) begin
      errors++; $display("[TB] FAIL prio_count: got %0d expected %0d", bus.stallCycleCount, exp_stalls);
    end
    go_idle();
    step();
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd0, 5'd0, 5'd9, 3'd4, 1'b1);
    #1;
    checks++;
    if (bus.isPipelineStalled !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_stall: got %b expected 0", bus.isPipelineStalled);
    end
    step();
    go_idle();
    #1;
    checks++;
    if (bus.busyRegisterMask[9] !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_mask9: got %b expected 0", bus.busyRegisterMask[9]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'd0, 5'd0, 5'd4, 3'd5, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd6, 3'd5, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd10, 3'd5, 1'b0);
    step();
    go_idle();
    #1;
    checks += 2;
    if (bus.busyRegisterMask !== 32'h0000_0450) begin
      errors++; $display("[TB] FAIL mid_busy: got %h expected 00000450", bus.busyRegisterMask);
    end
    if (bus.stallCycleCount !== 32'(exp_stalls)) begin
      errors++; $display("[TB] FAIL mid_count_before: got %0d expected %0d", bus.stallCycleCount, exp_stalls);
    end
    #2;
    reset = 1'b1;
    #1;
    checks += 2;
    if (bus.busyRegisterMask !== 32'h0) begin
      errors++; $display("[TB] FAIL mid_async_mask: got %h expected 0", bus.busyRegisterMask);
    end
    if (bus.stallCycleCount !== 32'h0) begin
      errors++; $display("[TB] FAIL mid_async_count: got %h expected 0", bus.stallCycleCount);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.busyRegisterMask !== 32'h0) begin
      errors++; $display("[TB] FAIL mid_after_mask: got %h expected 0", bus.busyRegisterMask);
    end
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count_q;
    bus.isInstructionMemoryBlocked = 1'b1;
    step();
    #1;
    checks++;
    if (bus.stallCycleCount !== 32'hFFFF_FFFF) begin
      errors++; $display("[TB] FAIL sat_reach: got %h expected ffffffff", bus.stallCycleCount);
    end
    step();
    step();
    #1;
    checks++;
    if (bus.stallCycleCount !== 32'hFFFF_FFFF) begin
      errors++; $display("[TB] FAIL sat_hold: got %h expected ffffffff", bus.stallCycleCount);
    end
    go_idle();
    step();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    exp_stalls = 0;
    test_reset();
    test_load_use();
    test_reg0();
    test_waw();
    test_latency_sweep();
    test_priority();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
